// File: rtl/spi_slave_gen.sv
// SPI slave with 2-FF pin synchronisers, configurable mode, width and bit order.
// Define SPI_SLAVE_GEN_TX_EN to build the MISO transmit path; otherwise RX only.
module spi_slave_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int SPI_MODE   = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  spi_sclk_in,
  input  logic                  spi_cs_in,
  input  logic                  spi_mosi_in,
  output logic                  spi_miso_out,
  output logic                  spi_miso_oe_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  transaction_valid_out,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  input  logic                  tx_load_in,
  output logic                  tx_ready_out
);

  localparam bit CPOL     = ((SPI_MODE >> 1) & 1) != 0;
  localparam bit CPHA     = (SPI_MODE & 1) != 0;
  localparam bit SMP_RISE = (CPOL == CPHA);
  localparam bit MSBF     = (MSB_FIRST != 0);
  localparam int CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic r_cs_s1, r_cs_s2, r_cs_d;
  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_mosi_s1, r_mosi_s2;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_d    <= 1'b1;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_cs_s1   <= spi_cs_in;
      r_cs_s2   <= r_cs_s1;
      r_cs_d    <= r_cs_s2;
      r_sclk_s1 <= spi_sclk_in;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_mosi_s1 <= spi_mosi_in;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  // Arm only once CS is seen high through a flushed synchroniser,
  // so a reset released mid-frame cannot start on a misaligned bit.
  logic [1:0] r_flush;
  logic       r_armed;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_flush <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      if (r_flush != 2'd3)
        r_flush <= r_flush + 2'd1;
      if (r_flush == 2'd3 && r_cs_s2)
        r_armed <= 1'b1;
    end
  end

  logic w_rise, w_fall, w_active, w_cs_fall;
  logic w_sample, w_shift, w_last;

  assign w_rise    = r_sclk_s2 & ~r_sclk_d;
  assign w_fall    = ~r_sclk_s2 & r_sclk_d;
  assign w_active  = r_armed & ~r_cs_s2;
  assign w_cs_fall = w_active & r_cs_d;
  assign w_sample  = w_active & (SMP_RISE ? w_rise : w_fall);
  assign w_shift   = w_active & (SMP_RISE ? w_fall : w_rise);

  assign transaction_valid_out = ~r_cs_s2;

  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_dv;
  logic [DATA_WIDTH-1:0] w_rx_next;

  assign w_last    = w_sample & (r_cnt == LAST);
  assign w_rx_next = MSBF ? {r_rx[DATA_WIDTH-2:0], r_mosi_s2}
                          : {r_mosi_s2, r_rx[DATA_WIDTH-1:1]};

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_cnt  <= '0;
      r_rx   <= '0;
      r_data <= '0;
      r_dv   <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      if (!w_active) begin
        r_cnt <= '0;
        r_rx  <= '0;
      end else if (w_sample) begin
        r_rx <= w_rx_next;
        if (w_last) begin
          r_cnt  <= '0;
          r_data <= w_rx_next;
          r_dv   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign data_out       = r_data;
  assign data_valid_out = r_dv;

`ifdef SPI_SLAVE_GEN_TX_EN
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_tx_sh;
  logic [DATA_WIDTH-1:0] w_next_word;
  logic                  r_hold_full;
  logic                  r_miso;
  logic                  w_bound;

  function automatic logic f_head(input logic [DATA_WIDTH-1:0] x);
    return MSBF ? x[DATA_WIDTH-1] : x[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_adv(
    input logic [DATA_WIDTH-1:0] x
  );
    return MSBF ? (x << 1) : (x >> 1);
  endfunction

  assign w_next_word = r_hold_full ? r_hold : '0;
  assign w_bound = CPHA ? (w_shift && (r_cnt == '0))
                        : (w_cs_fall || w_last);

  // r_tx_sh keeps the not-yet-driven bits front-aligned for the next shift.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_sh     <= '0;
      r_miso      <= 1'b0;
    end else begin
      if (w_bound)
        r_hold_full <= 1'b0;
      if (tx_load_in && (!r_hold_full || w_bound)) begin
        r_hold      <= tx_data_in;
        r_hold_full <= 1'b1;
      end
      if (!w_active) begin
        r_tx_sh <= '0;
        r_miso  <= 1'b0;
      end else if (w_bound) begin
        if (CPHA || w_cs_fall) begin
          r_miso  <= f_head(w_next_word);
          r_tx_sh <= f_adv(w_next_word);
        end else begin
          r_tx_sh <= w_next_word;
        end
      end else if (w_shift) begin
        r_miso  <= f_head(r_tx_sh);
        r_tx_sh <= f_adv(r_tx_sh);
      end
    end
  end

  assign spi_miso_out    = r_miso;
  assign spi_miso_oe_out = transaction_valid_out;
  assign tx_ready_out    = ~r_hold_full;
`else
  logic w_unused_tx;
  assign w_unused_tx     = ^{tx_data_in, tx_load_in};
  assign spi_miso_out    = 1'b0;
  assign spi_miso_oe_out = 1'b0;
  assign tx_ready_out    = 1'b0;
`endif

endmodule

// File: doc/spi_slave_gen.md
SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per SPI word (legal 4..32).
REQ-002 SHALL have parameter SPI_MODE, default 0, SPI mode 0..3 (bit1 = CPOL, bit0 = CPHA).
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 = MSB shifted first, 0 = LSB first.
REQ-004 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-005 reset_in  input  1  synchronous, active-high reset.
REQ-006 spi_sclk_in, spi_cs_in (active low), spi_mosi_in  input  1 each  asynchronous SPI pins.
REQ-007 spi_miso_out  output  1  serial transmit data.
REQ-008 spi_miso_oe_out  output  1  MISO output enable; tri-state control is external.
REQ-009 data_out  output  DATA_WIDTH  last complete received word.
REQ-010 data_valid_out  output  1  one-cycle pulse when data_out updates.
REQ-011 transaction_valid_out  output  1  high while synchronised CS is low.
REQ-012 tx_data_in  input  DATA_WIDTH  next word to transmit.
REQ-013 tx_load_in  input  1  write strobe for tx_data_in.
REQ-014 tx_ready_out  output  1  TX holding register empty.

Function
REQ-015 SHALL pass CS, SCLK and MOSI each through a 2-FF synchroniser; all logic SHALL use synchronised values only.
REQ-016 Sample edge SHALL be the rising synchronised SCLK edge when CPOL==CPHA, otherwise the falling edge; the shift edge SHALL be the opposite edge.
REQ-017 Edge detection SHALL compare the synchroniser output with a registered copy; timing is guaranteed for SCLK half-period >= 4 clk_in cycles.
REQ-018 On each sample edge with CS active, MOSI SHALL shift into the RX shift register in MSB_FIRST order and the bit counter (0..DATA_WIDTH-1) SHALL increment.
REQ-019 On the sample edge where the counter equals DATA_WIDTH-1, the counter SHALL wrap to 0; in the next cycle data_out SHALL hold the full word (including the bit just sampled) and data_valid_out SHALL be high for exactly one cycle.
REQ-020 Back-to-back words in one CS frame SHALL be received without gaps; multiple words per frame are legal.
REQ-021 CS deassertion mid-word SHALL clear the bit counter, discard the partial word and produce no data_valid_out pulse; data_out SHALL retain its previous value.
REQ-022 SCLK edges while CS is inactive SHALL be ignored.
REQ-023 tx_ready_out SHALL be high when the holding register is empty; tx_load_in while tx_ready_out is high SHALL capture tx_data_in and drop tx_ready_out the next cycle; tx_load_in while tx_ready_out is low SHALL be ignored.
REQ-024 At each word boundary, the holding register SHALL move to the TX shift register and tx_ready_out SHALL rise next cycle; if empty, an all-zero word SHALL be sent. Word boundary: CS falling edge (CPHA=0) or first shift edge of a word (CPHA=1), plus the last sample edge of each word (CPHA=0).
REQ-025 CPHA=0: first bit SHALL be on spi_miso_out within 1 cycle of synchronised CS falling; later bits SHALL advance on each shift edge. CPHA=1: each bit SHALL be driven on the shift edge preceding its sample edge.
REQ-026 spi_miso_oe_out SHALL equal transaction_valid_out.
REQ-027 A tx_load_in coinciding with a word-boundary transfer SHALL be accepted after the transfer (holding register refilled; tx_ready_out stays low).

Reset
REQ-028 Reset SHALL set: synchronised CS = 1, other synchroniser stages = 0, data_out = 0, data_valid_out = 0, transaction_valid_out = 0, spi_miso_out = 0, spi_miso_oe_out = 0, tx_ready_out = 1, all counters and shift registers = 0.
REQ-029 After reset, the receiver SHALL stay disarmed until synchronised CS is seen high, so reset in mid-frame never yields a misaligned word.

Configuration
REQ-030 Macro SPI_SLAVE_GEN_TX_EN: when defined, the transmit path (REQ-023..027) SHALL be built; when undefined, spi_miso_out, spi_miso_oe_out and tx_ready_out SHALL be tied to 0, tx_data_in and tx_load_in SHALL be ignored, and the RX path SHALL behave identically.

Verification
REQ-031 Mode 0, DATA_WIDTH=8, MSB-first: send 0xA5 then 0x3C in one frame -> two data_valid_out pulses, data_out 0xA5 then 0x3C.
REQ-032 Mode 3, DATA_WIDTH=16, LSB-first: send 0x1234 -> single pulse, data_out = 0x1234.
REQ-033 Mode 0: CS deasserted after 5 bits of 0xFF, then a full 0x81 frame -> no pulse for the partial word, then data_out = 0x81.
REQ-034 TX_EN, mode 1: load 0xC3 before the frame -> master reads 0xC3 on MISO; a second word with no load -> master reads 0x00; tx_ready_out = 1 after the first boundary.
REQ-035 Reset asserted at bit 3 of a frame, released while CS low -> no pulse until CS goes high; the next full frame with 0x5A -> data_out = 0x5A.
